veerwolf_uart_arb: RTL
======================

VEERWOLF_UART_ARB -- requirements
Module: veerwolf_uart_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesting cores (legal 2..10).
REQ-002 SHALL have parameter TIMEOUT, default 4096, idle cycles after which a held grant is released (legal 2..65535).
REQ-003 SHALL have port clk_core  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_core  in  1  asynchronous active-high reset.
REQ-005 SHALL have port i_req_data  in  8*NUM_REQ  byte from requester k at bits [8k+7:8k].
REQ-006 SHALL have port i_req_valid  in  NUM_REQ  requester byte valid; once high, held until its ready.
REQ-007 SHALL have port o_req_ready  out  NUM_REQ  byte accepted from requester k.
REQ-008 SHALL have port o_tx_data  out  8  byte to shared UART transmitter.
REQ-009 SHALL have port o_tx_valid  out  1  o_tx_data valid.
REQ-010 SHALL have port i_tx_ready  in  1  transmitter accepts byte.
REQ-011 SHALL have port o_grant  out  NUM_REQ  one-hot current owner, zero when idle.
REQ-012 SHALL have port o_busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, PFX_ID, PFX_COLON, FWD.
REQ-014 IDLE: if any i_req_valid bit is high, SHALL select the first set bit at or after rr_ptr (wrapping modulo NUM_REQ) and register it into o_grant; next state is PFX_ID (macro defined) or FWD.
REQ-015 Grant latency SHALL be exactly one cycle: request seen in cycle N, o_grant set and state left IDLE in cycle N+1.
REQ-016 FWD: o_tx_valid = i_req_valid[g], o_tx_data = i_req_data[g], o_req_ready[g] = i_tx_ready, all combinational; non-granted o_req_ready bits SHALL be 0.
REQ-017 FWD: on handshake (valid & ready) with byte 0x0A, SHALL return to IDLE, clear o_grant, and set rr_ptr = (g+1) mod NUM_REQ.
REQ-018 FWD: idle counter SHALL clear on every handshake and on FWD entry, and SHALL increment only while i_req_valid[g] is low.
REQ-019 FWD: when idle counter reaches TIMEOUT-1 with i_req_valid[g] low, SHALL return to IDLE with rr_ptr = (g+1) mod NUM_REQ; a grant SHALL never be released while o_tx_valid is high.
REQ-020 Simultaneous requests: only the selected requester SHALL be served; others wait with ready low, no byte lost or reordered.
REQ-021 Counter SHALL be 16 bits and saturate, never wrapping.
REQ-022 Bytes from different requesters SHALL never interleave within one grant.

Reset
REQ-023 During rst_core: state IDLE, rr_ptr 0, idle counter 0, o_grant 0, o_busy 0, o_tx_valid 0, o_req_ready 0, o_tx_data 0x00.
REQ-024 Reset asserted mid-transfer SHALL abort immediately; no partial prefix or byte SHALL be emitted after deassertion.

Configuration
REQ-025 Macro VEERWOLF_UART_ARB_PREFIX_EN defined: PFX_ID SHALL drive o_tx_valid=1, o_tx_data=0x30+g until i_tx_ready, then PFX_COLON drives 0x3A until i_tx_ready, then FWD; o_req_ready all 0 in both states.
REQ-026 Macro undefined: PFX_ID and PFX_COLON SHALL be unreachable; IDLE goes directly to FWD; output stream identical to requester bytes.

Structure
REQ-027 Package veerwolf_uart_arb_pkg SHALL hold the state enum and constants ASCII_LF (0x0A), ASCII_COLON (0x3A), ASCII_ZERO (0x30).
REQ-028 Round-robin priority selection SHALL be a sub-module veerwolf_rr_pick (inputs req vector and rr_ptr, output one-hot pick and index).

Verification
REQ-029 Single requester 1 sends "AB\n", i_tx_ready=1, no macro -> o_tx_data 0x41,0x42,0x0A on consecutive cycles; grant 0b0010 then 0; rr_ptr=2.
REQ-030 Requesters 0 and 2 valid together, rr_ptr=0 -> req0 line complete before any req2 byte; second grant 0b0100.
REQ-031 Requester 3 grants, sends "X", goes silent, TIMEOUT=16 -> release exactly 16 cycles after last handshake; waiting req0 granted next cycle.
REQ-032 i_tx_ready held low 100 cycles with requester valid -> grant held, no timeout, o_tx_data stable.
REQ-033 Macro defined, requester 2 sends "Z\n" -> stream 0x32,0x3A,0x5A,0x0A.
REQ-034 rst_core asserted during PFX_COLON -> all outputs 0 same cycle; after release, pending request re-arbitrated with rr_ptr=0 and full prefix resent.

Source files
------------

// File: rtl/veerwolf_uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : veerwolf_uart_arb_pkg
// Brief    : Shared types and constants for the VeeRwolf UART arbiter.
//            The arbiter's optional prefix feature is controlled by the
//            VEERWOLF_UART_ARB_PREFIX_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
package veerwolf_uart_arb_pkg;

  // Arbiter states; the two prefix states exist only when prefixing is built in
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PFX_ID    = 2'd1,
    ST_PFX_COLON = 2'd2,
    ST_FWD       = 2'd3
  } arb_state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Width of the idle-cycle counter
  localparam int CNT_W = 16;

  // Index width for a requester vector, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/veerwolf_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : veerwolf_rr_pick
// Brief    : Round-robin selector. Returns the first asserted request at or
//            after rr_ptr, wrapping modulo NUM_REQ, as one-hot and as index.
//            No configuration macros.
// Revision : 1.0 - initial release
// ============================================================================
module veerwolf_rr_pick
  import veerwolf_uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  // Scan from the farthest offset back to rr_ptr so the closest hit wins
  always_comb begin
    int w_pos;
    w_pos    = 0;
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = int'(rr_ptr) + i;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      if (req[w_pos[IDX_W-1:0]]) begin
        pick                      = '0;
        pick[w_pos[IDX_W-1:0]]    = 1'b1;
        pick_idx                  = w_pos[IDX_W-1:0];
        pick_any                  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/veerwolf_uart_arb.sv
`default_nettype none
// ============================================================================
// Module   : veerwolf_uart_arb
// Brief    : Shares one UART transmitter between NUM_REQ cores. A grant is
//            held for a whole line (until LF) or until the owner falls silent
//            for TIMEOUT cycles. Define VEERWOLF_UART_ARB_PREFIX_EN to tag
//            every line with "<id>:" before the owner's bytes.
// Revision : 1.0 - initial release
// ============================================================================
module veerwolf_uart_arb
  import veerwolf_uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk_core,
  input  logic                   rst_core,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy
);

  localparam int               IDX_W      = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_REQ - 1);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]    r_gidx;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]    r_idle_cnt;

  logic [NUM_REQ-1:0]  w_pick;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic [7:0]          w_sel_data;
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_next_ptr;

  veerwolf_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (i_req_valid),
    .rr_ptr   (r_rr_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .pick_any (w_pick_any)
  );

  // Owner's byte lane, selected by the one-hot grant
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_sel_data = w_sel_data | i_req_data[8*k +: 8];
      end
    end
  end

  assign w_sel_valid = |(i_req_valid & r_grant);
  assign w_next_ptr  = (r_gidx == c_idx_last) ? '0 : r_gidx + IDX_W'(1);
  assign o_grant     = r_grant;
  assign o_busy      = (r_state != ST_IDLE);

  // Transmit-side outputs: prefix bytes or a straight pass-through of the owner
  always_comb begin
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    case (r_state)
`ifdef VEERWOLF_UART_ARB_PREFIX_EN
      ST_PFX_ID: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_ZERO + 8'(r_gidx);
      end
      ST_PFX_COLON: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ASCII_COLON;
      end
`endif
      ST_FWD: begin
        o_tx_valid  = w_sel_valid;
        o_tx_data   = w_sel_data;
        o_req_ready = r_grant & {NUM_REQ{i_tx_ready}};
      end
      default: begin
      end
    endcase
  end

  // Grant lifecycle: arbitrate, optional prefix, forward until LF or silence
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant    <= w_pick;
            r_gidx     <= w_pick_idx;
            r_idle_cnt <= '0;
`ifdef VEERWOLF_UART_ARB_PREFIX_EN
            r_state    <= ST_PFX_ID;
`else
            r_state    <= ST_FWD;
`endif
          end
        end
`ifdef VEERWOLF_UART_ARB_PREFIX_EN
        ST_PFX_ID: begin
          if (i_tx_ready) begin
            r_state <= ST_PFX_COLON;
          end
        end
        ST_PFX_COLON: begin
          if (i_tx_ready) begin
            r_state    <= ST_FWD;
            r_idle_cnt <= '0;
          end
        end
`endif
        ST_FWD: begin
          if (w_sel_valid && i_tx_ready) begin
            // Any accepted byte restarts the silence window
            r_idle_cnt <= '0;
            if (w_sel_data == ASCII_LF) begin
              r_state  <= ST_IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
            end
          end else if (!w_sel_valid) begin
            // Release only while the owner is silent, so no offered byte is dropped
            if (r_idle_cnt == c_cnt_last) begin
              r_state    <= ST_IDLE;
              r_grant    <= '0;
              r_rr_ptr   <= w_next_ptr;
              r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_cnt_max) begin
              r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
